// File: rtl/painterengine_gpu_fill_source.sv
// Rectangle fill pixel source: raster-scans width x height, buffers pixels in a small FIFO for the DMA writer.
// Optional macro PAINTERENGINE_GPU_FILL_CHECKER_EN selects 8x8 checker tiles of color/color_alt.
module painterengine_gpu_fill_source #(
   parameter int unsigned PARAM_FIFO_DEPTH_LOG2 = 3
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_resetn,
   input  logic        i_wire_start,
   input  logic [15:0] i_wire_width,
   input  logic [15:0] i_wire_height,
   input  logic [31:0] i_wire_color,
   input  logic [31:0] i_wire_color_alt,
   output logic [31:0] o_wire_data,
   output logic        o_wire_data_valid,
   input  logic        i_wire_data_next,
   output logic [31:0] o_wire_length,
   output logic        o_wire_busy,
   output logic        o_wire_done,
   output logic        o_wire_error
);

   localparam int unsigned DEPTH = 1 << PARAM_FIFO_DEPTH_LOG2;
   localparam int unsigned CW    = PARAM_FIFO_DEPTH_LOG2 + 1;
   localparam int unsigned PW    = PARAM_FIFO_DEPTH_LOG2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_t;

   state_t      state;
   logic [15:0] width_q;
   logic [15:0] height_q;
   logic [15:0] x;
   logic [15:0] y;
   logic [31:0] color_q;
   logic [31:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic        push_c;
   logic        pop_c;
   logic        row_end_c;
   logic        last_c;
   logic [31:0] pixel_c;

   assign push_c    = (state == RUN) && (count < CW'(DEPTH));
   assign pop_c     = i_wire_data_next && (count != '0);
   assign row_end_c = (x == width_q - 16'd1);
   assign last_c    = row_end_c && (y == height_q - 16'd1);

`ifdef PAINTERENGINE_GPU_FILL_CHECKER_EN
   logic [31:0] color_alt_q;
   assign pixel_c = (x[3] ^ y[3]) ? color_alt_q : color_q;

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn)
         color_alt_q <= '0;
      else if ((state == IDLE || state == DONE) && i_wire_start)
         color_alt_q <= i_wire_color_alt;
   end
`else
   logic unused_color_alt;
   assign unused_color_alt = ^i_wire_color_alt;
   assign pixel_c = color_q;
`endif

   // Head word is masked while empty so outputs read zero out of reset.
   assign o_wire_data       = (count != '0) ? mem[rd_ptr] : 32'd0;
   assign o_wire_data_valid = (count != '0);

   always_ff @(posedge i_wire_clock) begin
      if (push_c)
         mem[wr_ptr] <= pixel_c;
   end

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state         <= IDLE;
         width_q       <= '0;
         height_q      <= '0;
         color_q       <= '0;
         x             <= '0;
         y             <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         o_wire_length <= '0;
         o_wire_busy   <= 1'b0;
         o_wire_done   <= 1'b0;
         o_wire_error  <= 1'b0;
      end else begin
         if (pop_c)
            rd_ptr <= rd_ptr + PW'(1);
         if (push_c)
            wr_ptr <= wr_ptr + PW'(1);
         if (push_c && !pop_c)
            count <= count + CW'(1);
         else if (pop_c && !push_c)
            count <= count - CW'(1);

         case (state)
            IDLE, DONE: begin
               if (i_wire_start) begin
                  width_q       <= i_wire_width;
                  height_q      <= i_wire_height;
                  color_q       <= i_wire_color;
                  x             <= '0;
                  y             <= '0;
                  rd_ptr        <= '0;
                  wr_ptr        <= '0;
                  count         <= '0;
                  o_wire_length <= '0;
                  o_wire_busy   <= 1'b1;
                  o_wire_done   <= 1'b0;
                  state         <= CHECK;
               end
            end
            CHECK: begin
               if (width_q == 16'd0 || height_q == 16'd0) begin
                  o_wire_busy  <= 1'b0;
                  o_wire_error <= 1'b1;
                  state        <= ERROR;
               end else begin
                  o_wire_length <= 32'(width_q) * 32'(height_q);
                  state         <= RUN;
               end
            end
            RUN: begin
               // Scan position only moves when the FIFO accepted the pixel.
               if (push_c) begin
                  if (row_end_c) begin
                     x <= '0;
                     y <= y + 16'd1;
                  end else begin
                     x <= x + 16'd1;
                  end
                  if (last_c)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (count == '0) begin
                  o_wire_busy <= 1'b0;
                  o_wire_done <= 1'b1;
                  state       <= DONE;
               end
            end
            ERROR: state <= ERROR;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_painterengine_gpu_fill_source.sv
// Scoreboard bench for painterengine_gpu_fill_source: expected pixels queued at start, monitor pops on each handshake.
module tb_painterengine_gpu_fill_source;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [15:0] width = '0;
   logic [15:0] height = '0;
   logic [31:0] color = '0;
   logic [31:0] color_alt = '0;
   logic        data_next = 1'b0;
   logic [31:0] data;
   logic        data_valid;
   logic [31:0] length;
   logic        busy;
   logic        done;
   logic        error;

   int          checks = 0;
   int          errors = 0;
   int          next_mode = 0;
   logic [31:0] exp_q[$];

   painterengine_gpu_fill_source #(.PARAM_FIFO_DEPTH_LOG2(3)) dut (
      .i_wire_clock      (clk),
      .i_wire_resetn     (resetn),
      .i_wire_start      (start),
      .i_wire_width      (width),
      .i_wire_height     (height),
      .i_wire_color      (color),
      .i_wire_color_alt  (color_alt),
      .o_wire_data       (data),
      .o_wire_data_valid (data_valid),
      .i_wire_data_next  (data_next),
      .o_wire_length     (length),
      .o_wire_busy       (busy),
      .o_wire_done       (done),
      .o_wire_error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference pixel: tile parity of the 8x8 grid picks the colour.
   function automatic logic [31:0] model_pixel(input int px, input int py,
                                               input logic [31:0] a, input logic [31:0] b);
`ifdef PAINTERENGINE_GPU_FILL_CHECKER_EN
      return (((px / 8) + (py / 8)) % 2 == 1) ? b : a;
`else
      return a;
`endif
   endfunction

   // data_next driver: 0 = held low, 1 = held high, otherwise random each cycle
   always @(posedge clk) begin
      #1;
      case (next_mode)
         0:       data_next = 1'b0;
         1:       data_next = 1'b1;
         default: data_next = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every accepted word is compared against the scoreboard head.
   always @(negedge clk) begin
      if (resetn && data_valid && data_next) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", data);
         end else begin
            check("pixel", data, exp_q.pop_front());
         end
      end
   end

   task automatic start_fill(input int w, input int h, input logic [31:0] c,
                             input logic [31:0] ca, input bit expect_words);
      @(posedge clk);
      #1;
      width     = 16'(w);
      height    = 16'(h);
      color     = c;
      color_alt = ca;
      start     = 1'b1;
      if (expect_words)
         for (int py = 0; py < h; py++)
            for (int px = 0; px < w; px++)
               exp_q.push_back(model_pixel(px, py, c, ca));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(done), 32'd1);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("rst_data", data, 32'd0);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_length", length, 32'd0);
      check("rst_flags", {29'd0, busy, done, error}, 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int h;
      logic [31:0] c;
      #12;
      check("init_data", data, 32'd0);
      check("init_valid", 32'(data_valid), 32'd0);
      check("init_length", length, 32'd0);
      check("init_flags", {29'd0, busy, done, error}, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Basic fill with start-to-valid latency
      next_mode = 1;
      start_fill(3, 2, 32'hFF00FF00, 32'h0, 1'b1);
      @(negedge clk);
      check("basic_busy", 32'(busy), 32'd1);
      check("basic_valid_early", 32'(data_valid), 32'd0);
      @(negedge clk);
      check("basic_length", length, 32'd6);
      @(negedge clk);
      check("basic_valid_lat", 32'(data_valid), 32'd1);
      wait_done("basic_done", 200);
      check("basic_drained", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      check("basic_no_more", 32'(data_valid), 32'd0);
      check("basic_done_hold", 32'(done), 32'd1);

      // Backpressure: FIFO fills and holds
      next_mode = 0;
      start_fill(20, 1, 32'h12345678, 32'h0, 1'b1);
      repeat (30) @(negedge clk);
      check("bp_valid", 32'(data_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_no_pops", 32'(exp_q.size()), 32'd20);
      next_mode = 1;
      wait_done("bp_done", 200);
      check("bp_drained", 32'(exp_q.size()), 32'd0);
      check("bp_length", length, 32'd20);

      // Checker tiles (solid colour when the option is off)
      next_mode = 2;
      start_fill(16, 1, 32'hAAAA0000, 32'h0000BBBB, 1'b1);
      wait_done("chk1_done", 500);
      check("chk1_drained", 32'(exp_q.size()), 32'd0);
      start_fill(16, 9, 32'hAAAA0000, 32'h0000BBBB, 1'b1);
      wait_done("chk9_done", 2000);
      check("chk9_drained", 32'(exp_q.size()), 32'd0);
      check("chk9_length", length, 32'd144);

      // Restart from DONE with random next
      start_fill(4, 4, 32'hCAFEF00D, 32'h0, 1'b1);
      wait_done("rs_done", 500);
      check("rs_drained", 32'(exp_q.size()), 32'd0);
      check("rs_length", length, 32'd16);

      // Random sizes and colours
      for (int r = 0; r < 6; r++) begin
         w = int'($urandom_range(1, 12));
         h = int'($urandom_range(1, 12));
         c = $urandom;
         start_fill(w, h, c, $urandom, 1'b1);
         wait_done("rand_done", 2000);
         check("rand_drained", 32'(exp_q.size()), 32'd0);
         check("rand_length", length, 32'(w * h));
      end

      // Zero-size error is sticky
      start_fill(0, 5, 32'h11111111, 32'h0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("err_flag", 32'(error), 32'd1);
      check("err_length", length, 32'd0);
      check("err_valid", 32'(data_valid), 32'd0);
      start_fill(3, 3, 32'h22222222, 32'h0, 1'b0);
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(error), 32'd1);
      check("err_not_busy", 32'(busy), 32'd0);
      check("err_valid2", 32'(data_valid), 32'd0);
      apply_reset();

      // Mid-run reset then a fresh small fill
      next_mode = 1;
      start_fill(100, 100, 32'h5A5A5A5A, 32'h0, 1'b1);
      repeat (50) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      apply_reset();
      start_fill(2, 2, 32'h0BADBEEF, 32'h0, 1'b1);
      wait_done("post_rst_done", 200);
      check("post_rst_drained", 32'(exp_q.size()), 32'd0);
      check("post_rst_length", length, 32'd4);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
